// File: rtl/rd_seq_pkg.sv
// Shared constants for the rd_seq_arbiter read-bus sequencer: one-hot state
// indices, the state width and the reset state.
package rd_seq_pkg;

    localparam int STATE_W = 4;

    localparam int IDLE = 0;
    localparam int READ = 1;
    localparam int DLY  = 2;
    localparam int DONE = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_RESET = 4'b0001;

    function automatic state_t st_onehot(input int idx);
        return state_t'(1) << idx;
    endfunction

endpackage

// File: rtl/rd_seq_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping around, returned both one-hot and as a binary index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    logic [IW-1:0] cand;
    logic          found;

    // NOTE: combinational logic uses blocking assignments, and every output
    // gets a default first so no latch is inferred.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            cand = IW'((int'(ptr) + off) % NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rd_seq_arbiter.sv
// Round-robin arbiter plus one-hot read sequencer driving a wait-stated bus.
// Optional build macro RD_SEQ_TIMEOUT_EN aborts an access after MAX_WS retries.
module rd_seq_arbiter
    import rd_seq_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int MAX_WS = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    done,
    output logic               err,
    output logic [DW-1:0]      rdata,
    output logic               bus_rd,
    output logic [AW-1:0]      bus_addr,
    input  logic               bus_ws,
    input  logic [DW-1:0]      bus_rdata,
    output logic [STATE_W-1:0] state,
    output logic               busy
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || MAX_WS < 1) begin : g_bad_param
        $error("rd_seq_arbiter: NREQ must be 2..8 and MAX_WS at least 1");
    end

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   idx_q;
    logic [NREQ-1:0] gnt_q;
    logic [AW-1:0]   addr_q;
    logic [NREQ-1:0] done_q;
    logic            err_q;
    logic [DW-1:0]   rdata_q;
    logic            bus_rd_q;
    logic [AW-1:0]   bus_addr_q;

`ifdef RD_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(MAX_WS + 1);
    logic [CW-1:0] retry_q;
`endif

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [AW-1:0]   pick_addr;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign pick_addr = req_addr[pick_idx*AW +: AW];

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the values from before this clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RESET;
            ptr_q      <= '0;
            idx_q      <= '0;
            gnt_q      <= '0;
            addr_q     <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            bus_rd_q   <= 1'b0;
            bus_addr_q <= '0;
`ifdef RD_SEQ_TIMEOUT_EN
            retry_q    <= '0;
`endif
        end else begin
            // Strobe, address and completion flags are single-cycle pulses.
            done_q     <= '0;
            err_q      <= 1'b0;
            bus_rd_q   <= 1'b0;
            bus_addr_q <= '0;
            case (1'b1)
                state_q[IDLE]: begin
                    if (pick_any) begin
                        idx_q      <= pick_idx;
                        gnt_q      <= pick_gnt;
                        addr_q     <= pick_addr;
                        bus_rd_q   <= 1'b1;
                        bus_addr_q <= pick_addr;
`ifdef RD_SEQ_TIMEOUT_EN
                        retry_q    <= '0;
`endif
                        state_q    <= st_onehot(READ);
                    end
                end
                state_q[READ]: begin
                    state_q <= st_onehot(DLY);
                end
                state_q[DLY]: begin
                    if (!bus_ws) begin
                        rdata_q <= bus_rdata;
                        done_q  <= gnt_q;
                        state_q <= st_onehot(DONE);
                    end
`ifdef RD_SEQ_TIMEOUT_EN
                    else if (retry_q == CW'(MAX_WS)) begin
                        done_q  <= gnt_q;
                        err_q   <= 1'b1;
                        state_q <= st_onehot(DONE);
                    end
`endif
                    else begin
`ifdef RD_SEQ_TIMEOUT_EN
                        retry_q    <= retry_q + CW'(1);
`endif
                        bus_rd_q   <= 1'b1;
                        bus_addr_q <= addr_q;
                        state_q    <= st_onehot(READ);
                    end
                end
                state_q[DONE]: begin
                    ptr_q   <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
                    state_q <= st_onehot(IDLE);
                end
                default: begin
                    state_q <= '0;
                end
            endcase
        end
    end

    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign bus_rd   = bus_rd_q;
    assign bus_addr = bus_addr_q;
    assign state    = state_q;
    assign busy     = !state_q[IDLE];

endmodule

// File: tb/tb_rd_seq_arbiter.sv
// Scoreboard bench for rd_seq_arbiter: a transaction-level model predicts
// grants, bus strobes, completions and per-cycle state; monitors compare.
module tb_rd_seq_arbiter;

    localparam int NREQ   = 4;
    localparam int AW     = 8;
    localparam int DW     = 8;
    localparam int MAX_WS = 3;
`ifdef RD_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [3:0] S_IDLE = 4'b0001;
    localparam logic [3:0] S_READ = 4'b0010;
    localparam logic [3:0] S_DLY  = 4'b0100;
    localparam logic [3:0] S_DONE = 4'b1000;

    typedef struct {
        int         cyc;
        logic [3:0] st;
        logic [7:0] rd;
    } cyc_item_t;

    typedef struct {
        int         cyc;
        logic [3:0] done;
        logic       err;
        logic [7:0] rdata;
    } txn_item_t;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
    } bus_item_t;

    bit                  clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ-1:0]     done;
    logic                err;
    logic [DW-1:0]       rdata;
    logic                bus_rd;
    logic [AW-1:0]       bus_addr;
    logic                bus_ws;
    logic [DW-1:0]       bus_rdata;
    logic [3:0]          state;
    logic                busy;

    rd_seq_arbiter #(
        .NREQ   (NREQ),
        .AW     (AW),
        .DW     (DW),
        .MAX_WS (MAX_WS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .bus_rd    (bus_rd),
        .bus_addr  (bus_addr),
        .bus_ws    (bus_ws),
        .bus_rdata (bus_rdata),
        .state     (state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    cyc_item_t cyc_q[$];
    txn_item_t txn_q[$];
    bus_item_t bus_q[$];

    // Reference model state: round-robin pointer and the held read data.
    int         ptr     = 0;
    logic [7:0] rdata_m = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: per-cycle state/busy/rdata, plus event-triggered done and bus checks.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (cyc_q.size() != 0 && cyc_q[0].cyc == cyc) begin
                cyc_item_t ci;
                ci = cyc_q.pop_front();
                check("state", state, ci.st);
                check("busy", busy, ci.st != S_IDLE);
                check("rdata_held", rdata, ci.rd);
            end
            if (done !== '0) begin
                if (txn_q.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    txn_item_t ti;
                    ti = txn_q.pop_front();
                    check("done_cycle", cyc, ti.cyc);
                    check("done_vec", done, ti.done);
                    check("err", err, ti.err);
                    check("rdata", rdata, ti.rdata);
                end
            end else begin
                check("err_idle", err, 1'b0);
            end
            if (bus_rd !== 1'b0) begin
                if (bus_q.size() == 0) begin
                    check("bus_rd_unexpected", bus_rd, 0);
                end else begin
                    bus_item_t bi;
                    bi = bus_q.pop_front();
                    check("bus_rd_cycle", cyc, bi.cyc);
                    check("bus_addr", bus_addr, bi.addr);
                end
            end
        end
    end

    function automatic int pick(input logic [3:0] rq);
        int j;
        for (int k = 0; k < NREQ; k++) begin
            j = (ptr + k) % NREQ;
            if (rq[j[1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic next_cycle(input logic [3:0] st);
        @(posedge clk);
        #1;
        cyc_q.push_back('{cyc, st, rdata_m});
    endtask

    task automatic drive_noise(input logic [3:0] rq, input bit hold);
        req       = hold ? rq : 4'($urandom);
        req_addr  = $urandom;
        bus_ws    = 1'($urandom);
        bus_rdata = 8'($urandom);
    endtask

    task automatic idle_cycle();
        next_cycle(S_IDLE);
        req       = '0;
        req_addr  = $urandom;
        bus_ws    = 1'($urandom);
        bus_rdata = 8'($urandom);
    endtask

    // One transaction from the IDLE sample cycle to its DONE cycle (or to a
    // reset applied in the first DLY cycle when rst_dly is set).
    task automatic run_txn(input logic [3:0] rq, input int waits, input logic [7:0] a_win,
                           input logic [7:0] d, input bit hold, input bit rst_dly);
        int  w;
        int  v;
        bit  fin;
        bit  abort;
        next_cycle(S_IDLE);
        w        = pick(rq);
        req      = rq;
        req_addr = $urandom;
        req_addr[w*AW +: AW] = a_win;
        bus_ws    = 1'($urandom);
        bus_rdata = 8'($urandom);
        v   = 0;
        fin = 0;
        while (!fin) begin
            next_cycle(S_READ);
            bus_q.push_back('{cyc, a_win});
            drive_noise(rq, hold);
            next_cycle(S_DLY);
            drive_noise(rq, hold);
            if (rst_dly) begin
                rst     = 1'b1;
                ptr     = 0;
                rdata_m = '0;
                next_cycle(S_IDLE);
                rst = 1'b0;
                req = '0;
                fin = 1;
            end else begin
                abort     = TO_EN && (v < waits) && (v == MAX_WS);
                bus_ws    = (v < waits);
                bus_rdata = d;
                if (v >= waits || abort) begin
                    if (!abort) rdata_m = d;
                    txn_q.push_back('{cyc + 1, 4'b0001 << w, abort, rdata_m});
                    next_cycle(S_DONE);
                    drive_noise(rq, hold);
                    ptr = (w + 1) % NREQ;
                    fin = 1;
                end
                v++;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_addr  = '0;
        bus_ws    = 1'b0;
        bus_rdata = '0;
        next_cycle(S_IDLE);
        next_cycle(S_IDLE);
        rst = 1'b0;
        repeat (3) idle_cycle();

        // Directed: single read, then the same read with two wait states.
        run_txn(4'b0001, 0, 8'h3C, 8'hA5, 1'b1, 1'b0);
        idle_cycle();
        run_txn(4'b0001, 2, 8'h3C, 8'hA5, 1'b1, 1'b0);
        idle_cycle();

        // Reset in DLY, then all requesters held: grants restart at pointer 0.
        run_txn(4'b0110, 0, 8'h11, 8'h22, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 0, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        idle_cycle();

        // Slave stuck in wait for 100+ cycles (aborts early in the timeout build).
        run_txn(4'b0001, 50, 8'h5A, 8'hC3, 1'b0, 1'b0);
        idle_cycle();

        for (int i = 0; i < 150; i++) begin
            int gap;
            int ws;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_cycle();
            ws = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 5);
            run_txn(4'($urandom_range(1, 15)), ws, 8'($urandom), 8'($urandom),
                    1'($urandom), $urandom_range(0, 19) == 0);
        end

        repeat (3) idle_cycle();
        @(posedge clk);
        #1;
        check("txn_queue_drained", txn_q.size(), 0);
        check("bus_queue_drained", bus_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rd_seq_arbiter.md
Name: rd_seq_arbiter

Overview:
- Shares one wait-stated read bus between NREQ requesters.
- Round-robin arbitration picks one requester; a one-hot sequencer (IDLE, READ, DLY, DONE) then runs that requester's read cycle.
- Each bus access is retried while the slave asserts its wait-state input.
- Sits between the requester ports and the shared read bus, as the sole bus master.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 8, address width.
- DW, 8, read data width.
- MAX_WS, 15, retry limit before abort (timeout build only); counter width = clog2(MAX_WS+1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester read request (level).
- req_addr  in  NREQ*AW  packed addresses; slice i = [i*AW +: AW].
- done  out  NREQ  one-cycle completion pulse, one-hot.
- err  out  1  asserted with done when the access was aborted.
- rdata  out  DW  read data; valid in the cycle done is high, held afterwards.
- bus_rd  out  1  bus read strobe.
- bus_addr  out  AW  bus address.
- bus_ws  in  1  slave wait-state; sampled in DLY.
- bus_rdata  in  DW  slave data; sampled in DLY when bus_ws=0.
- state  out  4  one-hot state, for debug.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - state = 4'b0001 (IDLE).
  - done, err, rdata, bus_rd, bus_addr: 0.
  - rr pointer, latched index, retry counter: 0.
- A reset mid-transaction aborts the transaction silently: no done pulse.
- State indices: IDLE=0, READ=1, DLY=2, DONE=3. Next-state logic is a case(1'b1) over state bits with a default next = 0. Exactly one state bit is set at all times.
- IDLE:
  - If any req bit is set, select the first set bit at or after the pointer, wrapping around.
  - Latch its index and address, clear the retry counter, go to READ.
  - With no requests, remain in IDLE.
- READ:
  - bus_rd = 1 and bus_addr = the latched address, both registered, for exactly this cycle.
  - Next state is always DLY.
- DLY, bus_rd = 0:
  - bus_ws = 0: rdata <= bus_rdata, go to DONE.
  - bus_ws = 1: increment the retry counter and go to READ, which re-strobes the bus.
- DONE:
  - done[idx] = 1 for one cycle.
  - pointer <= idx+1, wrapping from NREQ-1 to 0.
  - Next state is IDLE.
- Latency with no waits:
  - req sampled in cycle 0 (IDLE); READ in cycle 1; DLY in cycle 2; DONE with done pulse in cycle 3; IDLE in cycle 4.
  - Each wait adds 2 cycles.
  - Minimum request-to-request spacing is 4 cycles.
- Boundary cases:
  - Requester drops req mid-transaction: the transaction still completes and done still pulses.
  - req held after done: the requester is treated as a new request, subject to round-robin.
  - All requesters active: grant order is pointer, pointer+1, … ; no requester waits more than NREQ transactions.
  - req_addr is sampled only in IDLE; later changes are ignored.

Optional Feature:
- Macro: RD_SEQ_TIMEOUT_EN.
- Defined:
  - In DLY with bus_ws=1 and retry counter == MAX_WS: go to DONE with err=1 and rdata unchanged.
  - done pulses as normal.
- Undefined:
  - Waits indefinitely; no retry counter is instantiated.
  - err is tied to 0.
  - The port list is identical in both builds.

Decomposition:
- Package rd_seq_pkg:
  - State index localparams IDLE/READ/DLY/DONE.
  - State width 4.
  - Reset state constant 4'b0001.
- Sub-module rr_pick (combinational):
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant and its binary index, plus an any-request flag.
- The top level holds the FSM, latches and counter.

Test Plan:
- Reset held 2 cycles, then released with no req → state=0001, busy=0, bus_rd=0, done=0 on every cycle.
- req=0001, req_addr[0]=8'h3C, bus_ws=0, bus_rdata=8'hA5 → bus_rd=1 with bus_addr=8'h3C in cycle 1; done=0001 and rdata=8'hA5 in cycle 3.
- Same request with bus_ws=1 for the first 2 DLY cycles → bus_rd pulses 3 times; done in cycle 7; rdata correct.
- req=1111 held constantly, bus_ws=0 → done sequence 0001, 0010, 0100, 1000, 0001, with pulses 4 cycles apart.
- Timeout build, MAX_WS=3, bus_ws stuck at 1 → done=0001 with err=1 after 4 DLY visits; non-timeout build stays busy for 100 cycles.
- rst asserted in DLY → next cycle state=0001, no done pulse; a new request is then served from pointer 0.
